// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Resolves taken-branch flushes,
// load-use stalls and multi-cycle multiply holds, and keeps saturating
// performance counters for stall, load-use and flush cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal issue; branch / mul_start / load-use handled here
//   MUL_WAIT | multiply in flight; front end and EX held until done
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_mul_start,
  input  logic             i_cnt_clr,
  output logic             o_pc_w_en,
  output logic             o_if_id_w_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_ex_hold,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_lu_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MUL_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  state_t           r_state;
  logic [3:0]       r_mul_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_run;
  logic w_wait;
  logic w_lu;
  logic w_branch;
  logic w_mul;
  logic w_lu_stall;

  // Events are qualified by reset so the outputs sit at the idle defaults
  // while reset is held, whatever the pipeline inputs are doing.
  assign w_run      = i_rst_n & (r_state == S_RUN);
  assign w_wait     = i_rst_n & (r_state == S_MUL_WAIT);
  assign w_lu       = i_ex_mem_read & (i_ex_rt != 5'd0) &
                      ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));
  assign w_branch   = w_run & i_ex_branch_taken;
  assign w_mul      = w_run & ~i_ex_branch_taken & i_ex_mul_start;
  assign w_lu_stall = w_run & ~i_ex_branch_taken & ~i_ex_mul_start & w_lu;

  // Control outputs: combinational from state and the current cycle's inputs.
  always_comb begin
    o_pc_w_en      = ~(w_mul | w_lu_stall | w_wait);
    o_if_id_w_en   = ~(w_branch | w_mul | w_lu_stall | w_wait);
    o_if_id_flush  = w_branch;
    o_id_ex_bubble = w_branch | w_lu_stall;
    o_ex_hold      = w_mul | w_wait;
    o_busy         = w_wait;
  end

  // FSM and multiply down-counter; the start cycle counts as the first stall,
  // so MUL_WAIT lasts MUL_LAT-1 cycles and exits on a count of one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RUN;
      r_mul_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mul) begin
            r_mul_cnt <= MUL_LOAD;
            r_state   <= S_MUL_WAIT;
          end
        end
        S_MUL_WAIT: begin
          r_mul_cnt <= r_mul_cnt - 4'd1;
          if (r_mul_cnt == 4'd1) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_w_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_lu_stall && (r_lu_cnt != '1))    r_lu_cnt    <= r_lu_cnt + 1'b1;
      if (w_branch && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_lu_cnt    = r_lu_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for
// hazard_ctrl (MUL_LAT=4, CNT_W=4 so saturation is reachable quickly).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_mul_start, cnt_clr;
  logic       pc_w_en, if_id_w_en, if_id_flush, id_ex_bubble, ex_hold, busy;
  logic [3:0] stall_cnt, lu_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_rt(ex_rt), .i_ex_mem_read(ex_mem_read),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_mul_start(ex_mul_start),
    .i_cnt_clr(cnt_clr),
    .o_pc_w_en(pc_w_en), .o_if_id_w_en(if_id_w_en), .o_if_id_flush(if_id_flush),
    .o_id_ex_bubble(id_ex_bubble), .o_ex_hold(ex_hold), .o_busy(busy),
    .o_stall_cnt(stall_cnt), .o_lu_cnt(lu_cnt), .o_flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // pc, if_id_w, flush, bubble, hold, busy packed as one vector
  function automatic logic [5:0] ctl();
    return {pc_w_en, if_id_w_en, if_id_flush, id_ex_bubble, ex_hold, busy};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mul_start = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic [4:0] exrt);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_rt = exrt; ex_mem_read = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // load-use pattern present during reset must not disturb the defaults
    set_lu(5'd5, 5'd0, 1'b0, 5'd5);
    #3;
    chk("reset_ctl", 32'(ctl()), 32'b110000);
    chk("reset_cnt", {20'd0, stall_cnt, lu_cnt, flush_cnt}, 32'd0);
    cyc();
    chk("reset_hold_ctl", 32'(ctl()), 32'b110000);
    idle();
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl()), 32'b110000);
    cyc();

    // load-use on rs
    set_lu(5'd5, 5'd0, 1'b0, 5'd5); #1;
    chk("lu_rs_ctl", 32'(ctl()), 32'b000100);
    cyc(); idle(); #1;
    chk("lu_rs_one_cycle", 32'(ctl()), 32'b110000);
    chk("lu_rs_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h110);
    // ex_rt = 0 never stalls
    set_lu(5'd0, 5'd0, 1'b1, 5'd0); #1;
    chk("lu_r0_ctl", 32'(ctl()), 32'b110000);
    // rt match only when rt is a source
    set_lu(5'd3, 5'd7, 1'b0, 5'd7); #1;
    chk("lu_rt_unused", 32'(ctl()), 32'b110000);
    set_lu(5'd3, 5'd7, 1'b1, 5'd7); #1;
    chk("lu_rt_used", 32'(ctl()), 32'b000100);
    cyc(); idle(); #1;
    chk("lu_cnt2", {stall_cnt, lu_cnt, flush_cnt}, 32'h220);

    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0; #1;
    chk("clr_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h000);

    // multiply: 4 stalled cycles, busy on cycles 2-4; events ignored in MUL_WAIT
    ex_mul_start = 1'b1; #1;
    chk("mul_c1", 32'(ctl()), 32'b000010);
    cyc(); idle();
    ex_branch_taken = 1'b1; #1;
    chk("mul_c2_branch", 32'(ctl()), 32'b000011);
    cyc(); idle();
    ex_mul_start = 1'b1; #1;
    chk("mul_c3_mulstart", 32'(ctl()), 32'b000011);
    cyc(); idle();
    set_lu(5'd5, 5'd0, 1'b0, 5'd5); ex_branch_taken = 1'b1; #1;
    chk("mul_c4_lu_branch", 32'(ctl()), 32'b000011);
    cyc(); idle(); #1;
    chk("mul_done_ctl", 32'(ctl()), 32'b110000);
    chk("mul_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h400);

    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;

    // branch beats mul_start and load-use
    set_lu(5'd5, 5'd0, 1'b0, 5'd5); ex_branch_taken = 1'b1; ex_mul_start = 1'b1; #1;
    chk("br_prio_ctl", 32'(ctl()), 32'b101100);
    cyc(); idle(); #1;
    chk("br_stays_run", 32'(ctl()), 32'b110000);
    chk("br_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h001);

    // saturation: 20 load-use stall cycles on 4-bit counters
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    set_lu(5'd9, 5'd0, 1'b0, 5'd9);
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'hff0);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0; #1;
    chk("clr_over_inc", {stall_cnt, lu_cnt, flush_cnt}, 32'h000);
    cyc();
    chk("count_after_clr", {stall_cnt, lu_cnt, flush_cnt}, 32'h110);
    idle();

    // reset in the middle of MUL_WAIT aborts the stall asynchronously
    ex_mul_start = 1'b1; cyc(); idle(); cyc();
    chk("pre_rst_busy", 32'(ctl()), 32'b000011);
    #2 rst_n = 1'b0; #1;
    chk("rst_async_ctl", 32'(ctl()), 32'b110000);
    chk("rst_async_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h000);
    cyc();
    rst_n = 1'b1; #1;
    chk("post_rst_run", 32'(ctl()), 32'b110000);
    cyc();
    chk("post_rst_run2", 32'(ctl()), 32'b110000);
    chk("post_rst_cnt", {stall_cnt, lu_cnt, flush_cnt}, 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, total EX-stage multiply latency in cycles; legal range 2..15.
REQ-002 Parameter CNT_W, default 32, width of each performance counter.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_id_rs  input  5  rs field of instruction in ID.
REQ-006 i_id_rt  input  5  rt field of instruction in ID.
REQ-007 i_id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 i_ex_rt  input  5  destination register of instruction in EX.
REQ-009 i_ex_mem_read  input  1  EX instruction is a load.
REQ-010 i_ex_branch_taken  input  1  branch or jump in EX resolved taken this cycle.
REQ-011 i_ex_mul_start  input  1  multi-cycle multiply entered EX this cycle.
REQ-012 i_cnt_clr  input  1  synchronous clear of all performance counters.
REQ-013 o_pc_w_en  output  1  PC write enable.
REQ-014 o_if_id_w_en  output  1  IF/ID pipeline register write enable.
REQ-015 o_if_id_flush  output  1  IF/ID flush; discard fetched instruction.
REQ-016 o_id_ex_bubble  output  1  load NOP into ID/EX instead of the decoded instruction.
REQ-017 o_ex_hold  output  1  hold EX/ID-EX contents (multiply in progress).
REQ-018 o_busy  output  1  high while state is MUL_WAIT.
REQ-019 o_stall_cnt, o_lu_cnt, o_flush_cnt  output  CNT_W each  cycles with o_pc_w_en=0, load-use stalls, flushes.

Function
REQ-020 The FSM SHALL have two states, RUN and MUL_WAIT, plus a 4-bit down-counter mul_cnt.
REQ-021 Control outputs SHALL be combinational from state and current inputs; FSM, mul_cnt and counters SHALL be registered.
REQ-022 Default in RUN with no event: o_pc_w_en=1, o_if_id_w_en=1, o_if_id_flush=0, o_id_ex_bubble=0, o_ex_hold=0.
REQ-023 Load-use hazard (lu) SHALL be i_ex_mem_read & (i_ex_rt!=0) & ((i_ex_rt==i_id_rs) | (i_id_uses_rt & i_ex_rt==i_id_rt)).
REQ-024 RUN priority SHALL be: branch_taken > mul_start > lu.
REQ-025 RUN, i_ex_branch_taken=1: o_pc_w_en=1, o_if_id_w_en=0, o_if_id_flush=1, o_id_ex_bubble=1; state stays RUN; mul_start and lu ignored.
REQ-026 RUN, i_ex_mul_start=1 (no branch): o_pc_w_en=0, o_if_id_w_en=0, o_ex_hold=1, o_id_ex_bubble=0; mul_cnt<=MUL_LAT-1; next state MUL_WAIT.
REQ-027 MUL_WAIT: o_pc_w_en=0, o_if_id_w_en=0, o_ex_hold=1, o_if_id_flush=0, o_id_ex_bubble=0; mul_cnt decrements each cycle; when mul_cnt==1, next state RUN.
REQ-028 Total stalled cycles for one multiply SHALL equal MUL_LAT (start cycle plus MUL_LAT-1 MUL_WAIT cycles).
REQ-029 In MUL_WAIT, i_ex_branch_taken, i_ex_mul_start and lu SHALL be ignored.
REQ-030 RUN, lu=1 (no branch, no mul_start): o_pc_w_en=0, o_if_id_w_en=0, o_id_ex_bubble=1 for that cycle only; no state change.
REQ-031 o_if_id_flush and o_if_id_w_en SHALL never both be 1.
REQ-032 o_stall_cnt SHALL increment every cycle o_pc_w_en=0; o_lu_cnt on each REQ-030 cycle; o_flush_cnt on each REQ-025 cycle.
REQ-033 Counters SHALL saturate at all-ones and not wrap.
REQ-034 i_cnt_clr=1 SHALL zero all counters next edge, overriding any same-cycle increment; FSM unaffected.

Reset
REQ-035 On i_rst_n=0, state SHALL go to RUN, mul_cnt=0, all counters=0 immediately, regardless of clock.
REQ-036 During reset, outputs SHALL equal the REQ-022 defaults; o_busy=0.
REQ-037 Reset asserted in MUL_WAIT SHALL abort the multiply stall; first cycle after release is RUN.

Verification
REQ-038 ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle pc_w_en=0, if_id_w_en=0, id_ex_bubble=1; o_lu_cnt=1; same with ex_rt=0 -> no stall.
REQ-039 mul_start pulse, MUL_LAT=4 -> pc_w_en=0 and ex_hold=1 for exactly 4 cycles, o_busy=1 for cycles 2-4, o_stall_cnt=4.
REQ-040 branch_taken and mul_start and lu all 1 in RUN -> flush=1, bubble=1, pc_w_en=1, state stays RUN, o_flush_cnt=1.
REQ-041 branch_taken asserted during MUL_WAIT -> ignored; flush=0, stall ends on schedule.
REQ-042 CNT_W=4, 20 stall cycles -> o_stall_cnt holds 15; i_cnt_clr with concurrent stall -> 0 next cycle.
REQ-043 i_rst_n low mid-MUL_WAIT -> o_busy=0 and pc_w_en=1 asynchronously; counters 0.
